// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: control-field bit positions, WB control width
// and the two-state access FSM encoding.
package mem_pkg;

  localparam int MC_RD     = 0;
  localparam int MC_WR     = 1;
  localparam int MC_IMM    = 2;
  localparam int WB_CTRL_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when an outstanding data-memory access has
// waited TIMEOUT cycles; cleared at every issue.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  assign hit = (count == CW'(TIMEOUT - 1));

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: decodes EX/MEM control, runs loads/stores over a req/ack data
// memory port, stalls upstream while an access is pending and drives MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           MEM_WReg1,
  input  logic [63:0]          MEM_ALUoutput,
  input  logic [63:0]          MEM_R2out,
  input  logic [3:0]           MEM_MEM_CTRL,
  input  logic [WB_CTRL_W-1:0] MEM_WB_CTRL,
  input  logic [8:0]           MEM_IMM,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [63:0]          dmem_wdata,
  input  logic [63:0]          dmem_rdata,
  input  logic                 dmem_ack,
  output logic [4:0]           WB_WReg1,
  output logic [63:0]          WB_ALUoutput,
  output logic [63:0]          WB_MemData,
  output logic [WB_CTRL_W-1:0] WB_WB_CTRL,
  output logic                 mem_err
);

  logic [0:0]           state;
  logic [4:0]           lat_wreg;
  logic [63:0]          lat_alu;
  logic [WB_CTRL_W-1:0] lat_wb_ctrl;

  logic        mem_read, mem_write, add_imm, memop, is_store;
  logic [63:0] ea;
  logic        timeout_hit, ctr_clear, ctr_enable;
  logic        unused_bits;

  assign mem_read  = MEM_MEM_CTRL[MC_RD];
  assign mem_write = MEM_MEM_CTRL[MC_WR];
  assign add_imm   = MEM_MEM_CTRL[MC_IMM];
  assign memop     = mem_read | mem_write;
  // A read+write request is treated as a load; the write half is dropped.
  assign is_store  = mem_write & ~mem_read;
  assign ea        = MEM_ALUoutput + (add_imm ? {{55{MEM_IMM[8]}}, MEM_IMM} : 64'd0);

  assign unused_bits = ^{MEM_MEM_CTRL[3], ea[63:ADDR_W]};

  assign ctr_clear  = (state == ST_IDLE) && memop;
  assign ctr_enable = (state == ST_BUSY) && !dmem_ack && !timeout_hit;

  assign mem_stall = !reset &&
                     ((state == ST_IDLE) ? memop : (!dmem_ack && !timeout_hit));

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .hit    (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      lat_wreg     <= '0;
      lat_alu      <= '0;
      lat_wb_ctrl  <= '0;
      WB_WReg1     <= '0;
      WB_ALUoutput <= '0;
      WB_MemData   <= '0;
      WB_WB_CTRL   <= '0;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memop) begin
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= ea[ADDR_W-1:0];
            dmem_wdata  <= MEM_R2out;
            lat_wreg    <= MEM_WReg1;
            lat_alu     <= MEM_ALUoutput;
            lat_wb_ctrl <= MEM_WB_CTRL;
            WB_WB_CTRL  <= '0;
            state       <= ST_BUSY;
          end else begin
            WB_WReg1     <= MEM_WReg1;
            WB_ALUoutput <= MEM_ALUoutput;
            WB_MemData   <= '0;
            WB_WB_CTRL   <= MEM_WB_CTRL;
          end
        end
        default: begin
          // Ack takes priority over a coinciding timeout, leaving mem_err untouched.
          if (dmem_ack || timeout_hit) begin
            WB_WReg1     <= lat_wreg;
            WB_ALUoutput <= lat_alu;
            WB_WB_CTRL   <= lat_wb_ctrl;
            WB_MemData   <= (dmem_ack && !dmem_we) ? dmem_rdata : 64'd0;
            dmem_req     <= 1'b0;
            state        <= ST_IDLE;
            if (!dmem_ack) begin
              mem_err <= 1'b1;
            end
          end else begin
            WB_WB_CTRL <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level model
// of access latency, timeout and write-back results.
module tb_mem_access_unit;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  MEM_WReg1;
  logic [63:0] MEM_ALUoutput, MEM_R2out;
  logic [3:0]  MEM_MEM_CTRL;
  logic [1:0]  MEM_WB_CTRL;
  logic [8:0]  MEM_IMM;
  logic        mem_stall, dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [4:0]  WB_WReg1;
  logic [63:0] WB_ALUoutput, WB_MemData;
  logic [1:0]  WB_WB_CTRL;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int issues   = 0;
  int exp_issues = 0;
  logic req_q = 1'b0;
  logic err_model = 1'b0;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MEM_WReg1(MEM_WReg1), .MEM_ALUoutput(MEM_ALUoutput), .MEM_R2out(MEM_R2out),
    .MEM_MEM_CTRL(MEM_MEM_CTRL), .MEM_WB_CTRL(MEM_WB_CTRL), .MEM_IMM(MEM_IMM),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .WB_WReg1(WB_WReg1), .WB_ALUoutput(WB_ALUoutput),
    .WB_MemData(WB_MemData), .WB_WB_CTRL(WB_WB_CTRL), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Counts request issues (rising edges of dmem_req).
  always @(negedge clk) begin
    if (dmem_req && !req_q) issues <= issues + 1;
    req_q <= dmem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   dmem_req, 0);
    check({tag, "_we"},    dmem_we, 0);
    check({tag, "_addr"},  dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_wreg"},  WB_WReg1, 0);
    check({tag, "_alu"},   WB_ALUoutput, 0);
    check({tag, "_mdata"}, WB_MemData, 0);
    check({tag, "_wbctl"}, WB_WB_CTRL, 0);
    check({tag, "_err"},   mem_err, 0);
  endtask

  // One EX/MEM instruction, called at a falling edge. d = BUSY cycle index in which
  // ack arrives (d >= TIMEOUT means no ack). idle_ack pulses a stray ack on ALU ops.
  task automatic run_op(input logic [3:0] ctrl, input logic [4:0] wreg,
                        input logic [63:0] alu, input logic [63:0] r2,
                        input logic [8:0] imm, input logic [1:0] wb,
                        input int d, input logic [63:0] rdata, input bit idle_ack);
    logic memop, exp_we, to;
    logic [63:0] ea, exp_mdata;
    int end_k;
    bit done;
    memop  = ctrl[0] | ctrl[1];
    exp_we = ctrl[1] & ~ctrl[0];
    ea     = alu + (ctrl[2] ? {{55{imm[8]}}, imm} : 64'd0);
    MEM_MEM_CTRL  = ctrl;
    MEM_WReg1     = wreg;
    MEM_ALUoutput = alu;
    MEM_R2out     = r2;
    MEM_IMM       = imm;
    MEM_WB_CTRL   = wb;
    dmem_ack      = idle_ack && !memop;
    dmem_rdata    = {$urandom, $urandom};
    #1;
    if (!memop) begin
      check("alu_stall", mem_stall, 0);
      @(posedge clk); @(negedge clk);
      dmem_ack = 1'b0;
      check("alu_wreg", WB_WReg1, wreg);
      check("alu_alu", WB_ALUoutput, alu);
      check("alu_wbctl", WB_WB_CTRL, wb);
      check("alu_mdata", WB_MemData, 0);
      check("alu_req", dmem_req, 0);
      check("alu_err", mem_err, err_model);
    end else begin
      exp_issues++;
      check("issue_stall", mem_stall, 1);
      to    = (d >= TIMEOUT);
      end_k = to ? TIMEOUT - 1 : d;
      done  = 1'b0;
      for (int k = 0; k < TIMEOUT + 4 && !done; k++) begin
        @(posedge clk); @(negedge clk);
        check("busy_req", dmem_req, 1);
        check("busy_we", dmem_we, exp_we);
        check("busy_addr", dmem_addr, ea[ADDR_W-1:0]);
        check("busy_wdata", dmem_wdata, r2);
        check("busy_bubble", WB_WB_CTRL, 0);
        if (k == d) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        #1;
        check("busy_stall", mem_stall, (k != end_k));
        if (k == end_k) begin
          @(posedge clk); @(negedge clk);
          dmem_ack = 1'b0;
          if (to) err_model = 1'b1;
          exp_mdata = (to || exp_we) ? 64'd0 : rdata;
          check("done_wreg", WB_WReg1, wreg);
          check("done_alu", WB_ALUoutput, alu);
          check("done_wbctl", WB_WB_CTRL, wb);
          check("done_mdata", WB_MemData, exp_mdata);
          check("done_req", dmem_req, 0);
          check("done_err", mem_err, err_model);
          done = 1'b1;
        end
      end
      if (!done) check("busy_bound", 0, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    MEM_WReg1 = '0; MEM_ALUoutput = '0; MEM_R2out = '0; MEM_MEM_CTRL = '0;
    MEM_WB_CTRL = '0; MEM_IMM = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", mem_stall, 0);
    check_zero_outputs("rst");
    reset = 1'b0;

    // ALU pass-through, then boundary: ack coinciding with the timeout cycle.
    run_op(4'b0000, 5'd5, 64'h1234, 64'h0, 9'h0, 2'b10, 0, 64'h0, 1'b0);
    run_op(4'b0001, 5'd7, 64'h40, 64'h0, 9'h0, 2'b01, TIMEOUT - 1, 64'h5555, 1'b0);
    // Load with negative offset, ack after 3 cycles.
    run_op(4'b0101, 5'd9, 64'h100, 64'h0, 9'h1FC, 2'b11, 3, 64'hDEAD, 1'b0);
    check("load_addr_fc", dmem_addr, 10'h0FC);
    // Store acked in the first request cycle.
    run_op(4'b0010, 5'd3, 64'h200, 64'hBEEF, 9'h0, 2'b10, 0, 64'h7777, 1'b0);
    // Back-to-back loads, then read+write behaves as a load.
    run_op(4'b0001, 5'd1, 64'h10, 64'h0, 9'h0, 2'b11, 1, 64'hA1, 1'b0);
    run_op(4'b0001, 5'd2, 64'h20, 64'h0, 9'h0, 2'b11, 2, 64'hA2, 1'b0);
    run_op(4'b0011, 5'd4, 64'h30, 64'h99, 9'h0, 2'b11, 0, 64'hA3, 1'b0);
    // Timeout, stray ack while idle, sticky error.
    run_op(4'b0001, 5'd6, 64'h50, 64'h0, 9'h0, 2'b10, 1000, 64'hBAD, 1'b0);
    run_op(4'b0000, 5'd8, 64'h77, 64'h0, 9'h0, 2'b01, 0, 64'h0, 1'b1);
    run_op(4'b0010, 5'd11, 64'h60, 64'h42, 9'h0, 2'b10, 2, 64'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] c;
      c = 4'($urandom);
      run_op(c, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             9'($urandom), 2'($urandom), $urandom_range(0, TIMEOUT + 2),
             {$urandom, $urandom}, 1'($urandom));
    end

    // Reset held 3 cycles in the middle of an access, with a late ack.
    MEM_MEM_CTRL = 4'b0001; MEM_WB_CTRL = 2'b11; MEM_WReg1 = 5'd12;
    MEM_ALUoutput = 64'h88; dmem_ack = 1'b0;
    exp_issues++;
    @(posedge clk); @(negedge clk);
    check("rst_busy_req", dmem_req, 1);
    reset = 1'b1;
    #1;
    check("rst_busy_stall", mem_stall, 0);
    @(posedge clk); @(negedge clk);
    check_zero_outputs("rst_mid");
    dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    err_model = 1'b0;
    MEM_MEM_CTRL = '0; MEM_WB_CTRL = '0; MEM_WReg1 = '0; MEM_ALUoutput = '0;
    MEM_R2out = '0; MEM_IMM = '0;
    #1;
    check("post_rst_stall", mem_stall, 0);
    @(posedge clk); @(negedge clk);
    check_zero_outputs("post_rst");

    @(posedge clk); #1;
    check("issue_count", issues, exp_issues);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
